// File: rtl/psg_audio_pkg.sv
// Shared constants and types for the PSG audio back-end.
package psg_audio_pkg;

   localparam int SUM_W     = 10;  // width of a+b+c (max 765)
   localparam int OUT_W     = 16;  // PCM sample width
   localparam int OUT_SCALE = 5;   // left shift from 11-bit signed to PCM

   typedef logic signed [OUT_W-1:0] psg_pcm_t;

   // Sign-extend an 11-bit signed level to PCM width and apply the output gain.
   function automatic psg_pcm_t scale_pcm(input logic signed [SUM_W:0] y);
      psg_pcm_t w;
      w = {{(OUT_W-SUM_W-1){y[SUM_W]}}, y};
      return w <<< OUT_SCALE;
   endfunction

endpackage

// File: rtl/psg_dcblock.sv
// Leaky DC tracker: subtracts the running mean of the decimated level and
// scales the result to PCM. Produces a one-cycle load strobe per sample.
module psg_dcblock
   import psg_audio_pkg::*;
#(
   parameter int DC_SHIFT = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SUM_W-1:0] avg_r,
   input  logic             avg_v,
   input  logic             mute,
   output psg_pcm_t         y_scaled,
   output logic             load
);

   localparam int DC_W = SUM_W + DC_SHIFT;

   logic [DC_W-1:0]         dc_acc;
   logic [SUM_W-1:0]        dc;
   logic signed [SUM_W:0]   y;

   // Current DC estimate, offset-removed level and scaled (or muted) sample.
   always_comb begin
      dc       = SUM_W'(dc_acc >> DC_SHIFT);
      y        = {1'b0, avg_r} - {1'b0, dc};
      y_scaled = mute ? '0 : scale_pcm(y);
      load     = avg_v;
   end

   // Tracker update; keeps running while muted so the estimate stays current.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dc_acc <= '0;
      end else if (avg_v) begin
         dc_acc <= dc_acc + DC_W'(avg_r) - DC_W'(dc);
      end
   end

endmodule

// File: rtl/psg_decim.sv
// PSG audio back-end: sums the three channel levels, box-car decimates by
// 2^DECIM_LOG2, removes DC and presents signed PCM through a valid/ready
// register with a sticky overrun flag.
module psg_decim
   import psg_audio_pkg::*;
#(
   parameter int DECIM_LOG2 = 3,
   parameter int DC_SHIFT   = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] c,
   input  logic       mute,
   input  logic       clr_drop,
   output psg_pcm_t   out_sample,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       dropped
);

   localparam int ACC_W = SUM_W + DECIM_LOG2;
   // A zero-width counter is not legal, so DECIM_LOG2=0 uses one bit pinned at 0.
   localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << DECIM_LOG2) - 1);

   logic [SUM_W-1:0] sum;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_next;
   logic [CNT_W-1:0] cnt;
   logic [SUM_W-1:0] avg_r;
   logic             avg_v;
   psg_pcm_t         y_scaled;
   logic             load;
   logic             drop_now;

   // Channel sum and the accumulator value including the current strobe.
   always_comb begin
      sum      = SUM_W'(a) + SUM_W'(b) + SUM_W'(c);
      acc_next = acc + ACC_W'(sum);
   end

   // Box-car decimator: the last strobe of a group emits the mean and restarts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         cnt   <= '0;
         avg_r <= '0;
         avg_v <= 1'b0;
      end else begin
         avg_v <= 1'b0;
         if (cen) begin
            if (cnt == CNT_MAX) begin
               avg_r <= SUM_W'(acc_next >> DECIM_LOG2);
               avg_v <= 1'b1;
               acc   <= '0;
               cnt   <= '0;
            end else begin
               acc <= acc_next;
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   psg_dcblock #(
      .DC_SHIFT (DC_SHIFT)
   ) u_dcblock (
      .clk      (clk),
      .rst      (rst),
      .avg_r    (avg_r),
      .avg_v    (avg_v),
      .mute     (mute),
      .y_scaled (y_scaled),
      .load     (load)
   );

   // An overrun is a new load while the held sample is neither consumed nor ready.
   always_comb begin
      drop_now = load & out_valid & ~out_ready;
   end

   // Output register: new samples always win; a handshake alone only clears valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_sample <= '0;
         out_valid  <= 1'b0;
         dropped    <= 1'b0;
      end else begin
         if (load) begin
            out_sample <= y_scaled;
            out_valid  <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (drop_now) begin
            dropped <= 1'b1;
         end else if (clr_drop) begin
            dropped <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_psg_decim.sv
// Scoreboard bench for psg_decim: one instance with DECIM_LOG2=3 for the
// grouping/DC/overrun/mute scenarios, one with DECIM_LOG2=0 for throughput.
module tb_psg_decim;
   import psg_audio_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance with DECIM_LOG2=3
   logic       cen, mute, clr_drop, out_ready;
   logic [7:0] a, b, c;
   psg_pcm_t   out_sample;
   logic       out_valid, dropped;

   // Instance with DECIM_LOG2=0
   logic       cen0, mute0, clr_drop0, ready0;
   logic [7:0] a0, b0, c0;
   psg_pcm_t   out_sample0;
   logic       out_valid0, dropped0;

   psg_decim #(.DECIM_LOG2(3), .DC_SHIFT(9)) dut (
      .clk(clk), .rst(rst), .cen(cen), .a(a), .b(b), .c(c),
      .mute(mute), .clr_drop(clr_drop), .out_sample(out_sample),
      .out_valid(out_valid), .out_ready(out_ready), .dropped(dropped)
   );

   psg_decim #(.DECIM_LOG2(0), .DC_SHIFT(9)) dut0 (
      .clk(clk), .rst(rst), .cen(cen0), .a(a0), .b(b0), .c(c0),
      .mute(mute0), .clr_drop(clr_drop0), .out_sample(out_sample0),
      .out_valid(out_valid0), .out_ready(ready0), .dropped(dropped0)
   );

   int total = 0;
   int bad   = 0;
   int q[$];
   int q0[$];
   int pops0 = 0;
   bit skip = 1'b0;
   int sk_cnt = 0;
   int sk_last = 0;
   int sk_max = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Monitor for the decimating instance: pops on each handshake.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (skip) begin
            sk_cnt++;
            sk_last = int'(out_sample);
            if ((sk_last < 0 ? -sk_last : sk_last) > sk_max)
               sk_max = (sk_last < 0 ? -sk_last : sk_last);
         end else if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_sample: got %0d, expected none", out_sample);
         end else begin
            chk("sample", int'(out_sample), q.pop_front());
         end
      end
   end

   // Monitor for the full-rate instance.
   always @(negedge clk) begin
      if (!rst && out_valid0 && ready0) begin
         pops0++;
         if (q0.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_sample0: got %0d, expected none", out_sample0);
         end else begin
            chk("sample0", int'(out_sample0), q0.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic group(input int n, input int va, input int vb, input int vc);
      a   = 8'(va);
      b   = 8'(vb);
      c   = 8'(vc);
      cen = 1'b1;
      tick(n);
      cen = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (q.size() != 0 && k < 50) begin
         tick(1);
         k++;
      end
      chk(name, q.size(), 0);
   endtask

   task automatic reset_pulse();
      #3;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   int va0[10] = '{1, 10, 0, 7, 50, 0, 30, 0, 255, 0};
   int vb0[10] = '{2, 0, 20, 7, 0, 0, 30, 0, 255, 0};
   int vc0[10] = '{3, 0, 5, 7, 0, 100, 30, 0, 255, 0};
   int ex0[10] = '{192, 320, 800, 672, 1600, 3200, 2880, 0, 24480, -64};

   initial begin
      rst = 1'b1;
      cen = 1'b0; a = '0; b = '0; c = '0;
      mute = 1'b0; clr_drop = 1'b0; out_ready = 1'b1;
      cen0 = 1'b0; a0 = '0; b0 = '0; c0 = '0;
      mute0 = 1'b0; clr_drop0 = 1'b0; ready0 = 1'b1;

      // Reset state
      tick(2);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_sample", int'(out_sample), 0);
      chk("rst_dropped", int'(dropped), 0);
      rst = 1'b0;
      tick(1);

      // Silent group: one zero sample, two cycles after the 8th strobe
      q.push_back(0);
      group(8, 0, 0, 0);
      chk("zero_valid_n", int'(out_valid), 0);
      tick(1);
      chk("zero_valid_n1", int'(out_valid), 1);
      chk("zero_sample", int'(out_sample), 0);
      tick(1);
      chk("zero_valid_n2", int'(out_valid), 0);
      wait_drain("zero_drain");

      // Full-scale single channel, then long run for DC decay
      reset_pulse();
      q.push_back(8160);
      q.push_back(8160);
      group(16, 255, 0, 0);
      wait_drain("step_drain");
      tick(2);
      skip = 1'b1; sk_cnt = 0; sk_max = 0;
      group(8 * 4998, 255, 0, 0);
      tick(3);
      chk("decay_count", sk_cnt, 4998);
      chk_range("decay_level", sk_last, -99, 99);
      skip = 1'b0;

      // Overrun: second value replaces first, dropped sets
      reset_pulse();
      out_ready = 1'b0;
      group(8, 255, 0, 0);
      group(8, 100, 0, 0);
      tick(1);
      chk("ovr_sample", int'(out_sample), 3200);
      chk("ovr_valid", int'(out_valid), 1);
      chk("ovr_dropped", int'(dropped), 1);
      clr_drop = 1'b1;
      tick(1);
      clr_drop = 1'b0;
      chk("clr_dropped", int'(dropped), 0);
      chk("clr_valid_held", int'(out_valid), 1);
      // New drop in the same cycle as clr_drop: drop wins
      clr_drop = 1'b1;
      group(8, 50, 0, 0);
      tick(1);
      clr_drop = 1'b0;
      chk("prio_dropped", int'(dropped), 1);
      chk("prio_sample", int'(out_sample), 1600);
      q.push_back(1600);
      out_ready = 1'b1;
      tick(1);
      chk("hs_valid_fall", int'(out_valid), 0);
      tick(1);
      chk("hs_sample_hold", int'(out_sample), 1600);
      clr_drop = 1'b1;
      tick(1);
      clr_drop = 1'b0;
      chk("clr2_dropped", int'(dropped), 0);
      wait_drain("ovr_drain");

      // Asynchronous reset mid-cycle with a pending sample
      out_ready = 1'b0;
      group(8, 255, 0, 0);
      tick(1);
      chk("pend_valid", int'(out_valid), 1);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid", int'(out_valid), 0);
      chk("arst_sample", int'(out_sample), 0);
      chk("arst_dropped", int'(dropped), 0);
      tick(1);
      rst = 1'b0;
      tick(1);
      chk("arst_dropped_after", int'(dropped), 0);

      // Reset mid-group discards the partial accumulation
      group(4, 200, 0, 0);
      #3;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      group(8, 200, 0, 0);
      chk("midgrp_valid_n", int'(out_valid), 0);
      tick(1);
      chk("midgrp_valid_n1", int'(out_valid), 1);
      chk("midgrp_sample", int'(out_sample), 6400);
      q.push_back(6400);
      out_ready = 1'b1;
      wait_drain("midgrp_drain");

      // Mute: outputs zero while the DC tracker keeps running
      reset_pulse();
      mute = 1'b1;
      skip = 1'b1; sk_cnt = 0; sk_max = 0;
      group(8 * 512, 200, 0, 0);
      tick(3);
      chk("mute_count", sk_cnt, 512);
      chk("mute_peak", sk_max, 0);
      mute = 1'b0;
      sk_cnt = 0;
      group(8, 200, 0, 0);
      tick(3);
      chk("unmute_count", sk_cnt, 1);
      chk_range("unmute_level", sk_last, 1, 3199);
      skip = 1'b0;

      // Full-rate instance: one sample per cycle, including the peak level
      for (int i = 0; i < 10; i++) begin
         a0 = 8'(va0[i]);
         b0 = 8'(vb0[i]);
         c0 = 8'(vc0[i]);
         cen0 = 1'b1;
         q0.push_back(ex0[i]);
         tick(1);
         if (i >= 1) chk("rate_valid", int'(out_valid0), 1);
      end
      cen0 = 1'b0;
      tick(4);
      chk("rate_drain", q0.size(), 0);
      chk("rate_pops", pops0, 10);
      chk("rate_dropped", int'(dropped0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
